vram_access_arbiter: RTL and testbench

- Shares one single-port synchronous pixel RAM between two requesters:
  - the real-time display scan-out path, which feeds the RGB pixel loader;
  - a host write port that updates frame contents.
- Display reads always win. Host writes are buffered in a small FIFO and drained on cycles the display leaves free, optionally only during blanking.
- Runs on the pixel clock, alongside the H/V sync timing generator.

---
 rtl/vram_access_arbiter.sv | 130 +++++++++++++
 tb/tb_vram_access_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_access_arbiter.sv
// Shares one single-port synchronous pixel RAM between display scan-out reads
// and a FIFO-buffered host write port; display reads always win.
module vram_access_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 6,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 1024,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_blank,
  input  logic              blank_only,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              wr_starved,
  input  logic              starve_clr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_cnt_next;
  logic              fifo_empty;
  logic              drain_ok;
  logic              push;
  logic              pop;
  logic              starve_set;

  // A full FIFO refuses writes even when it is popping the same cycle.
  assign wr_ready   = fifo_level < LVL_W'(DEPTH);
  assign fifo_empty = fifo_level == '0;
  assign drain_ok   = !blank_only || in_blank;
  assign push       = wr_valid && wr_ready;
  assign pop        = !disp_req && !fifo_empty && drain_ok;
  assign disp_rdata = ram_rdata;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Idle cycles keep the last address/data on the bus to avoid needless toggling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      disp_rvalid <= 1'b0;
    end else begin
      disp_rvalid <= ram_en && !ram_we;
      if (disp_req) begin
        ram_en   <= 1'b1;
        ram_we   <= 1'b0;
        ram_addr <= disp_addr;
      end else if (pop) begin
        ram_en    <= 1'b1;
        ram_we    <= 1'b1;
        ram_addr  <= fifo_addr[rd_ptr];
        ram_wdata <= fifo_data[rd_ptr];
      end else begin
        ram_en <= 1'b0;
        ram_we <= 1'b0;
      end
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt;
    if (pop || fifo_empty) begin
      starve_cnt_next = '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt_next = starve_cnt + CNT_W'(1);
    end
  end

  // Re-asserting while saturated lets an ongoing starvation override a clear.
  assign starve_set = starve_cnt_next == CNT_W'(STARVE_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      wr_starved <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_next;
      if (starve_set) begin
        wr_starved <= 1'b1;
      end else if (starve_clr) begin
        wr_starved <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Self-checking bench for vram_access_arbiter: behavioural pixel RAM, a
// reference FIFO model and scoreboards for RAM commands and display data.
module tb_vram_access_arbiter;

  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 6;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int LVL_W        = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_blank;
  logic              blank_only;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [LVL_W-1:0]  fifo_level;
  logic              wr_starved;
  logic              starve_clr;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  vram_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_blank(in_blank), .blank_only(blank_only),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rvalid(disp_rvalid),
    .disp_rdata(disp_rdata), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .fifo_level(fifo_level),
    .wr_starved(wr_starved), .starve_clr(starve_clr), .ram_en(ram_en),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } item_t;

  item_t             mdl_q[$];
  item_t             exp_wr_q[$];
  item_t             rd_cmd_q[$];
  item_t             rd_data_q[$];
  logic [DATA_W-1:0] ram_mem [1024];
  logic [DATA_W-1:0] shadow [1024];
  logic              cmd_en;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  int                cyc = 0;
  int                n_checks = 0;
  int                n_fail = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Mid-cycle: outputs are stable, so compare them against the scoreboards.
  task automatic monitorCycle();
    item_t e;
    cmd_en    = ram_en;
    cmd_we    = ram_we;
    cmd_addr  = ram_addr;
    cmd_wdata = ram_wdata;
    if (ram_en && ram_we) begin
      if (exp_wr_q.size() == 0) begin
        checkOutput("unexpected_wr", 32'(ram_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_wr_q.pop_front();
        checkOutput("wr_addr", 32'(ram_addr), 32'(e.addr));
        checkOutput("wr_data", 32'(ram_wdata), 32'(e.data));
        checkOutput("wr_cycle", cyc, e.cyc);
      end
    end
    if (ram_en && !ram_we) begin
      if (rd_cmd_q.size() == 0) begin
        checkOutput("unexpected_rd", 32'(ram_addr), 32'hFFFF_FFFF);
      end else begin
        e = rd_cmd_q.pop_front();
        checkOutput("rd_addr", 32'(ram_addr), 32'(e.addr));
        checkOutput("rd_cycle", cyc, e.cyc);
      end
    end
    if (disp_rvalid) begin
      if (rd_data_q.size() == 0) begin
        checkOutput("unexpected_rvalid", 32'(disp_rdata), 32'hFFFF_FFFF);
      end else begin
        e = rd_data_q.pop_front();
        checkOutput("rd_data", 32'(disp_rdata), 32'(e.data));
        checkOutput("rvalid_cycle", cyc, e.cyc);
      end
    end
    if (exp_wr_q.size() != 0 && exp_wr_q[0].cyc < cyc) begin
      e = exp_wr_q.pop_front();
      checkOutput("wr_missing", cyc, e.cyc);
    end
    if (rd_cmd_q.size() != 0 && rd_cmd_q[0].cyc < cyc) begin
      e = rd_cmd_q.pop_front();
      checkOutput("rd_missing", cyc, e.cyc);
    end
    if (rd_data_q.size() != 0 && rd_data_q[0].cyc < cyc) begin
      e = rd_data_q.pop_front();
      checkOutput("rvalid_missing", cyc, e.cyc);
    end
    checkOutput("fifo_level", 32'(fifo_level), mdl_q.size());
    checkOutput("wr_ready", 32'(wr_ready), (mdl_q.size() < DEPTH) ? 1 : 0);
  endtask

  // Clock edge: the pixel RAM acts on the command just seen, and the reference
  // model arbitrates on the inputs that were held through the cycle.
  task automatic modelEdge();
    item_t e;
    bit    pop_m;
    bit    push_m;
    cyc++;
    if (cmd_en) begin
      if (cmd_we) ram_mem[cmd_addr[9:0]] = cmd_wdata;
      else        ram_rdata = ram_mem[cmd_addr[9:0]];
    end
    if (!rst_n) begin
      mdl_q.delete();
      exp_wr_q.delete();
      rd_cmd_q.delete();
      rd_data_q.delete();
    end else begin
      pop_m  = !disp_req && mdl_q.size() != 0 && (!blank_only || in_blank);
      push_m = wr_valid && mdl_q.size() < DEPTH;
      if (disp_req) begin
        e.addr = disp_addr;
        e.data = '0;
        e.cyc  = cyc;
        rd_cmd_q.push_back(e);
        e.data = shadow[disp_addr[9:0]];
        e.cyc  = cyc + 1;
        rd_data_q.push_back(e);
      end else if (pop_m) begin
        e = mdl_q.pop_front();
        e.cyc = cyc;
        exp_wr_q.push_back(e);
        shadow[e.addr[9:0]] = e.data;
      end
      if (push_m) begin
        e.addr = wr_addr;
        e.data = wr_data;
        e.cyc  = 0;
        mdl_q.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      monitorCycle();
      @(posedge clk);
      modelEdge();
      #1;
    end
  endtask

  task automatic waitDrain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (fifo_level != '0 && n < max_cycles) begin
      applyStimulus(1);
      n++;
    end
    checkOutput(tag, 32'(fifo_level), 0);
    applyStimulus(2);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  j;
    int  n;
    bit  acc;
    rst_n      = 1'b0;
    in_blank   = 1'b0;
    blank_only = 1'b0;
    disp_req   = 1'b0;
    disp_addr  = '0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    starve_clr = 1'b0;
    ram_rdata  = '0;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 6'(i * 5 + 3);
      shadow[i]  = 6'(i * 5 + 3);
    end
    ram_mem[16] = 6'h2A;
    shadow[16]  = 6'h2A;

    $display("[TB] reset state");
    applyStimulus(2);
    checkOutput("rst_ram_en", 32'(ram_en), 0);
    checkOutput("rst_ram_we", 32'(ram_we), 0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 0);
    checkOutput("rst_ram_wdata", 32'(ram_wdata), 0);
    checkOutput("rst_rvalid", 32'(disp_rvalid), 0);
    checkOutput("rst_starved", 32'(wr_starved), 0);
    checkOutput("rst_level", 32'(fifo_level), 0);
    rst_n = 1'b1;
    applyStimulus(1);

    $display("[TB] single display read");
    disp_req  = 1'b1;
    disp_addr = 19'h00010;
    applyStimulus(1);
    disp_req = 1'b0;
    checkOutput("t1_ram_en", 32'(ram_en), 1);
    checkOutput("t1_ram_we", 32'(ram_we), 0);
    checkOutput("t1_ram_addr", 32'(ram_addr), 32'h10);
    applyStimulus(1);
    checkOutput("t1_rvalid", 32'(disp_rvalid), 1);
    checkOutput("t1_rdata", 32'(disp_rdata), 32'h2A);
    applyStimulus(2);

    $display("[TB] host burst with display idle");
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 19'h100 + 19'(i);
      wr_data  = 6'(i + 1);
      checkOutput("t2_ready", 32'(wr_ready), 1);
      applyStimulus(1);
    end
    wr_valid = 1'b0;
    waitDrain("t2_drained", 20);

    $display("[TB] writes blocked by continuous display reads");
    disp_req = 1'b1;
    j = 0;
    for (int c = 0; c < 6; c++) begin
      disp_addr = 19'h100 + 19'(c % 4);
      wr_valid  = 1'b1;
      wr_addr   = 19'h100 + 19'(j);
      wr_data   = 6'h30 + 6'(j);
      acc       = mdl_q.size() < DEPTH;
      applyStimulus(1);
      if (acc) j++;
    end
    checkOutput("t3_accepted", j, 4);
    checkOutput("t3_ready_full", 32'(wr_ready), 0);
    checkOutput("t3_level_full", 32'(fifo_level), 4);
    disp_req = 1'b0;
    n = 0;
    while (j < 6 && n < 20) begin
      wr_addr = 19'h100 + 19'(j);
      wr_data = 6'h30 + 6'(j);
      acc     = mdl_q.size() < DEPTH;
      applyStimulus(1);
      if (acc) j++;
      n++;
    end
    checkOutput("t3_all_accepted", j, 6);
    wr_valid = 1'b0;
    waitDrain("t3_drained", 20);

    $display("[TB] blanking-only drain");
    blank_only = 1'b1;
    in_blank   = 1'b0;
    wr_valid   = 1'b1;
    wr_addr    = 19'h200;
    wr_data    = 6'h3F;
    applyStimulus(1);
    wr_valid = 1'b0;
    applyStimulus(3);
    checkOutput("t4_held_level", 32'(fifo_level), 1);
    checkOutput("t4_held_no_en", 32'(ram_en), 0);
    in_blank = 1'b1;
    applyStimulus(1);
    checkOutput("t4_level", 32'(fifo_level), 0);
    checkOutput("t4_ram_we", 32'(ram_we), 1);
    checkOutput("t4_ram_addr", 32'(ram_addr), 32'h200);
    checkOutput("t4_ram_wdata", 32'(ram_wdata), 32'h3F);
    applyStimulus(1);
    in_blank   = 1'b0;
    blank_only = 1'b0;

    $display("[TB] starvation flag");
    disp_req  = 1'b1;
    disp_addr = 19'h00010;
    wr_valid  = 1'b1;
    wr_addr   = 19'h300;
    wr_data   = 6'h15;
    applyStimulus(1);
    wr_valid = 1'b0;
    applyStimulus(STARVE_LIMIT - 1);
    checkOutput("t5_not_yet", 32'(wr_starved), 0);
    applyStimulus(1);
    checkOutput("t5_starved", 32'(wr_starved), 1);
    starve_clr = 1'b1;
    applyStimulus(1);
    starve_clr = 1'b0;
    checkOutput("t5_set_wins", 32'(wr_starved), 1);
    disp_req = 1'b0;
    applyStimulus(1);
    checkOutput("t5_sticky", 32'(wr_starved), 1);
    checkOutput("t5_drained", 32'(fifo_level), 0);
    starve_clr = 1'b1;
    applyStimulus(1);
    starve_clr = 1'b0;
    checkOutput("t5_cleared", 32'(wr_starved), 0);
    applyStimulus(2);

    $display("[TB] reset during drain");
    disp_req  = 1'b1;
    disp_addr = 19'h00020;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 19'h380 + 19'(i);
      wr_data  = 6'h20 + 6'(i);
      applyStimulus(1);
    end
    wr_valid = 1'b0;
    disp_req = 1'b0;
    applyStimulus(1);
    checkOutput("t6_level3", 32'(fifo_level), 3);
    rst_n = 1'b0;
    applyStimulus(1);
    rst_n = 1'b1;
    checkOutput("t6_rst_level", 32'(fifo_level), 0);
    checkOutput("t6_rst_en", 32'(ram_en), 0);
    applyStimulus(10);

    checkOutput("end_wr_pending", exp_wr_q.size(), 0);
    checkOutput("end_rd_pending", rd_cmd_q.size(), 0);
    checkOutput("end_rdata_pending", rd_data_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
